volume_ctrl: RTL and testbench

Digital volume stage for the 24-bit audio datapath. It attenuates each incoming sample by a power of two, using a right shift held in a saturating register. The shift amount is stepped at run time by two level-sensitive control inputs, `up_i` and `down_i`. The block sits between the sample source (codec/DSP chain) and the output serializer and does not touch sample timing.

---
 rtl/volume_pkg.sv | 16 +
 rtl/volume_step_counter.sv | 57 +++++
 rtl/volume_ctrl.sv | 80 ++++++++
 tb/tb_volume_ctrl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/volume_pkg.sv
// Shared constants and types for the volume stage: sample width, shift limits,
// reset shift and the 3-bit shift type.
package volume_pkg;

    localparam int sample_width_c = 24;
    localparam int shift_min_c    = 1;
    localparam int shift_max_c    = 7;
    localparam int shift_reset_c  = 3;

    typedef logic [2:0] shift_t;

    function automatic logic shift_in_range(input shift_t shift, input shift_t lo, input shift_t hi);
        shift_in_range = (shift >= lo) && (shift <= hi);
    endfunction

endpackage

// File: rtl/volume_step_counter.sv
// Saturating up/down attenuation register. It steps once per cycle while a
// single control input is high and holds at the limits without wrapping.
module volume_step_counter
    import volume_pkg::*;
#(
    parameter int shift_reset_p = shift_reset_c,
    parameter int shift_min_p   = shift_min_c,
    parameter int shift_max_p   = shift_max_c
) (
    input  logic   clk_i,
    input  logic   reset_i,
    input  logic   up_i,
    input  logic   down_i,
    output shift_t shift_o
);

    localparam shift_t reset_val_c = shift_t'(shift_reset_p);
    localparam shift_t min_val_c   = shift_t'(shift_min_p);
    localparam shift_t max_val_c   = shift_t'(shift_max_p);

    shift_t shift_q;
    shift_t shift_d;

    // Next-shift selection from the level-sensitive controls, clamped at both limits
    always_comb begin
        shift_d = shift_q;
        case ({up_i, down_i})
            2'b10: begin
                if (shift_q < max_val_c) begin
                    shift_d = shift_q + 3'd1;
                end else begin
                    shift_d = shift_q;
                end
            end
            2'b01: begin
                if (shift_q > min_val_c) begin
                    shift_d = shift_q - 3'd1;
                end else begin
                    shift_d = shift_q;
                end
            end
            default: shift_d = shift_q;
        endcase
    end

    // Shift register with synchronous reset to the default attenuation
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shift_q <= reset_val_c;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign shift_o = shift_q;

endmodule

// File: rtl/volume_ctrl.sv
// Digital volume stage: zero-latency logical right shift of each unsigned sample
// by a registered, saturating attenuation amount.
module volume_ctrl
    import volume_pkg::*;
#(
    parameter int width_p       = sample_width_c,
    parameter int shift_reset_p = shift_reset_c,
    parameter int shift_min_p   = shift_min_c,
    parameter int shift_max_p   = shift_max_c
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] sound_i,
    input  logic               up_i,
    input  logic               down_i,
    output logic [width_p-1:0] sound_o
);

    shift_t             shift_r;
    logic [width_p-1:0] sound_s;

    volume_step_counter #(
        .shift_reset_p (shift_reset_p),
        .shift_min_p   (shift_min_p),
        .shift_max_p   (shift_max_p)
    ) u_step_counter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .up_i    (up_i),
        .down_i  (down_i),
        .shift_o (shift_r)
    );

    // Barrel shift; shift 0 is unreachable, so the fallback mutes rather than passes full scale
    always_comb begin
        sound_s = {width_p{1'b0}};
        case (shift_r)
            3'd1:    sound_s = sound_i >> 3'd1;
            3'd2:    sound_s = sound_i >> 3'd2;
            3'd3:    sound_s = sound_i >> 3'd3;
            3'd4:    sound_s = sound_i >> 3'd4;
            3'd5:    sound_s = sound_i >> 3'd5;
            3'd6:    sound_s = sound_i >> 3'd6;
            3'd7:    sound_s = sound_i >> 3'd7;
            default: sound_s = {width_p{1'b0}};
        endcase
    end

    assign sound_o = sound_s;

    volume_shift_chk #(
        .shift_min_p (shift_min_p),
        .shift_max_p (shift_max_p)
    ) u_shift_chk (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .shift_i (shift_r)
    );

endmodule

// Range checker for the attenuation register.
module volume_shift_chk
    import volume_pkg::*;
#(
    parameter int shift_min_p = shift_min_c,
    parameter int shift_max_p = shift_max_c
) (
    input logic   clk_i,
    input logic   reset_i,
    input shift_t shift_i
);

    localparam shift_t min_val_c = shift_t'(shift_min_p);
    localparam shift_t max_val_c = shift_t'(shift_max_p);

    a_shift_in_range: assert property (@(posedge clk_i) disable iff (reset_i)
        shift_in_range(shift_i, min_val_c, max_val_c));

endmodule

// File: tb/tb_volume_ctrl.sv
// Directed bench for volume_ctrl: reset default, clamps at both ends,
// simultaneous/idle controls, a mixed sequence and a mid-run reset.
module tb_volume_ctrl;

    logic        clk;
    logic        reset_i;
    logic [23:0] sound_i;
    logic        up_i;
    logic        down_i;
    logic [23:0] sound_o;

    int total_cnt;
    int bad_cnt;

    volume_ctrl dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .sound_i (sound_i),
        .up_i    (up_i),
        .down_i  (down_i),
        .sound_o (sound_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%06h, expected 0x%06h", tag, obs, exp);
        end
    endtask

    // One clock: apply controls/sample after a falling edge, let the rising edge pass,
    // return at the next falling edge so outputs are sampled mid-cycle.
    task automatic run_cycle(input logic up, input logic down, input logic [23:0] snd);
        up_i    = up;
        down_i  = down;
        sound_i = snd;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Down clamp: shifts 2,1,1 with 0x40
    logic [23:0] down_exp [3] = '{24'h000010, 24'h000020, 24'h000020};
    // Up clamp: shifts 2..7,7,7 with 0x800000
    logic [23:0] up_exp [8] = '{24'h200000, 24'h100000, 24'h080000, 24'h040000,
                                24'h020000, 24'h010000, 24'h010000, 24'h010000};
    // Mixed sequence: controls {up,down} and resulting shift after each edge
    logic [1:0] mix_ctl   [12] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b11, 2'b10,
                                   2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b00};
    int         mix_shift [12] = '{2, 1, 1, 2, 2, 3, 4, 5, 4, 3, 4, 4};

    initial begin
        logic [23:0] snd;
        total_cnt = 0;
        bad_cnt   = 0;
        reset_i   = 1'b1;
        up_i      = 1'b0;
        down_i    = 1'b0;
        sound_i   = 24'h000000;

        // Reset held 10 cycles, controls ignored during reset
        repeat (9) @(negedge clk);
        up_i = 1'b1;
        @(negedge clk);
        up_i    = 1'b0;
        reset_i = 1'b0;
        sound_i = 24'h000010;
        #1 check_val("reset_small", sound_o, 24'h000002);
        sound_i = 24'hFFFFFF;
        #1 check_val("reset_full", sound_o, 24'h1FFFFF);

        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b0, 1'b1, 24'h000040);
            check_val($sformatf("down_%0d", i), sound_o, down_exp[i]);
        end

        for (int i = 0; i < 8; i++) begin
            run_cycle(1'b1, 1'b0, 24'h800000);
            check_val($sformatf("up_%0d", i), sound_o, up_exp[i]);
        end

        // Both high then both low: shift stays 7, output follows input immediately
        run_cycle(1'b1, 1'b1, 24'h800000);
        check_val("both_0", sound_o, 24'h010000);
        run_cycle(1'b1, 1'b1, 24'hABCDEF);
        check_val("both_1", sound_o, 24'h01579B);
        run_cycle(1'b0, 1'b0, 24'h000080);
        check_val("idle_0", sound_o, 24'h000001);
        sound_i = 24'hFFFFFF;
        #1 check_val("idle_comb", sound_o, 24'h01FFFF);
        run_cycle(1'b0, 1'b0, 24'h123456);
        check_val("idle_1", sound_o, 24'h002468);

        // Back to shift 3 for the mixed sequence
        reset_i = 1'b1;
        run_cycle(1'b0, 1'b1, 24'h800000);
        reset_i = 1'b0;
        check_val("rst_to_3", sound_o, 24'h100000);

        snd = 24'd0;
        for (int i = 0; i < 12; i++) begin
            run_cycle(mix_ctl[i][1], mix_ctl[i][0], snd);
            check_val($sformatf("mix_%0d", i), sound_o, snd >> mix_shift[i]);
            snd = (snd + 24'd1) * 24'd2;
        end

        // Mid-run reset with up held: shift 4 -> 3, then resumes stepping
        reset_i = 1'b1;
        run_cycle(1'b1, 1'b0, 24'h800000);
        check_val("midrst", sound_o, 24'h100000);
        reset_i = 1'b0;
        run_cycle(1'b1, 1'b0, 24'h800000);
        check_val("post_rst_up", sound_o, 24'h080000);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
